// File: rtl/add_sub_arbiter.sv
// Two-port round-robin arbiter sharing one 5-bit add/subtract datapath.
// Optional signed-overflow flags are enabled by defining ADD_SUB_OVERFLOW_FLAG_EN.
module add_sub_arbiter (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       op0,
   input  logic [4:0] a0,
   input  logic [4:0] b0,
   output logic       ack0,
   output logic [4:0] res0,
   input  logic       req1,
   input  logic       op1,
   input  logic [4:0] a1,
   input  logic [4:0] b1,
   output logic       ack1,
   output logic [4:0] res1,
   output logic       busy
`ifdef ADD_SUB_OVERFLOW_FLAG_EN
   ,
   output logic       ovf0,
   output logic       ovf1
`endif
);

   typedef enum logic [1:0] {StIdle, StExec, StDone} state_t;

   state_t     state;
   logic       grant;
   logic       last_grant;
   logic       op_l;
   logic [4:0] a_l;
   logic [4:0] b_l;
   logic [4:0] work;
   logic [4:0] b_eff;
   logic [4:0] sum;
   logic       pick;

   // Subtract is a + ~b + 1; carry-out is dropped by the 5-bit width.
   assign b_eff = op_l ? ~b_l : b_l;
   assign sum   = a_l + b_eff + {4'b0000, op_l};

   // On a tie the port that did not win last time is granted.
   assign pick  = (req0 && req1) ? ~last_grant : req1;

`ifdef ADD_SUB_OVERFLOW_FLAG_EN
   logic ovf_w;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= StIdle;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         op_l       <= 1'b0;
         a_l        <= '0;
         b_l        <= '0;
         work       <= '0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         res0       <= '0;
         res1       <= '0;
         busy       <= 1'b0;
`ifdef ADD_SUB_OVERFLOW_FLAG_EN
         ovf_w      <= 1'b0;
         ovf0       <= 1'b0;
         ovf1       <= 1'b0;
`endif
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (state)
            StIdle: begin
               if (req0 || req1) begin
                  grant <= pick;
                  op_l  <= pick ? op1 : op0;
                  a_l   <= pick ? a1 : a0;
                  b_l   <= pick ? b1 : b0;
                  state <= StExec;
                  busy  <= 1'b1;
               end
            end
            StExec: begin
               work  <= sum;
`ifdef ADD_SUB_OVERFLOW_FLAG_EN
               ovf_w <= (a_l[4] == b_eff[4]) && (sum[4] != a_l[4]);
`endif
               state <= StDone;
            end
            StDone: begin
               if (grant) begin
                  res1 <= work;
                  ack1 <= 1'b1;
`ifdef ADD_SUB_OVERFLOW_FLAG_EN
                  ovf1 <= ovf_w;
`endif
               end else begin
                  res0 <= work;
                  ack0 <= 1'b1;
`ifdef ADD_SUB_OVERFLOW_FLAG_EN
                  ovf0 <= ovf_w;
`endif
               end
               last_grant <= grant;
               state      <= StIdle;
               busy       <= 1'b0;
            end
            default: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/add_sub_arbiter.md
ADD_SUB_ARBITER -- requirements
Module: add_sub_arbiter

Interface
REQ-001 Reset is synchronous and active-high; the design SHALL use one clock `clk` and one reset `reset`.
REQ-002 The ports SHALL be, one per line, name / direction / width / meaning:
- clk in 1: rising-edge clock.
- reset in 1: synchronous, active-high reset.
- req0 in 1: port-0 request.
- op0 in 1: port-0 operation; 0 = add, 1 = subtract.
- a0 in 5: port-0 operand A.
- b0 in 5: port-0 operand B.
- ack0 out 1: port-0 completion pulse.
- res0 out 5: port-0 result.
- req1, op1, a1, b1, ack1, res1: same as port 0, for port 1.
- busy out 1: operation in progress.
- ovf0, ovf1 out 1: signed-overflow flags; present only under REQ-019.

Function
REQ-003 The block SHALL time-share a single 5-bit add/subtract datapath between ports 0 and 1: result = a + b, or a + ~b + 1 when op = 1, modulo 32, with carry-out discarded.
REQ-004 The FSM SHALL use states IDLE, EXEC and DONE; all state and outputs are registered.
REQ-005 IDLE: if any req is high at a clock edge, the block SHALL latch the granted port's op, a and b plus the grant index, and go to EXEC; otherwise it stays in IDLE.
REQ-006 EXEC: the block SHALL compute from the latched operands only, register the result into a working register, and go to DONE.
REQ-007 DONE: the block SHALL copy the result into the granted port's res, assert that port's ack for exactly this one cycle, update last_grant, and return to IDLE.
REQ-008 Latency: a req sampled in IDLE at edge N SHALL give ack high during the cycle after edge N+2. Throughput is one operation per 3 cycles.
REQ-009 Arbitration SHALL be round-robin:
- Only one req high: that port is granted.
- Both high: the port not equal to last_grant is granted.
REQ-010 ack0 and ack1 SHALL never be high in the same cycle.
REQ-011 Requesters hold req/op/a/b stable until ack; the block SHALL ignore req, op and operand changes while in EXEC or DONE.
REQ-012 A req still high in the cycle after its ack SHALL be treated as a new request.
REQ-013 res of the port not being served SHALL hold its value; each res holds its last result until that port's next completion.
REQ-014 busy SHALL be high whenever state != IDLE.
REQ-015 A req that drops during EXEC or DONE SHALL NOT abort the operation; ack still pulses.

Reset
REQ-016 When reset is sampled high, the block SHALL go to IDLE and discard any latched operation; no ack is issued for it.
REQ-017 Reset values SHALL be: ack0 = ack1 = 0, res0 = res1 = 0, busy = 0, working register = 0, last_grant = 1 (port 0 wins the first tie). ovf0/ovf1 = 0 when present.
REQ-018 Reset SHALL take priority over all other events in the same cycle, including an ack due that cycle.

Configuration
REQ-019 Macro ADD_SUB_OVERFLOW_FLAG_EN:
- Defined: ports ovf0/ovf1 SHALL exist. Overflow is registered in EXEC and presented with res in DONE: overflow = (a[4] == b'[4]) && (sum[4] != a[4]), where b' is the effective second operand (b, or ~b for subtract). The non-served port's ovf holds its value.
- Not defined: ovf0/ovf1 and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-020 After reset, req0 = 1, op0 = 0, a0 = 7, b0 = 9 at edge 0 -> ack0 high after edge 2, res0 = 16, ack1 = 0 throughout.
REQ-021 req1 = 1, op1 = 1, a1 = 3, b1 = 5 -> res1 = 30 (0x1E), ovf1 = 0 with the macro; res0 is unchanged.
REQ-022 After reset, req0 and req1 both high from edge 0 -> ack0 after edge 2, ack1 after edge 5. With both held high, the acks alternate 0, 1, 0, 1.
REQ-023 With the macro: op0 = 0, a0 = 12, b0 = 6 -> res0 = 18, ovf0 = 1. Then op0 = 1, a0 = 16, b0 = 1 -> res0 = 15, ovf0 = 1.
REQ-024 reset pulsed for one cycle while busy = 1 in EXEC -> no ack ever issued for that request, res unchanged, busy = 0 the cycle after reset.
REQ-025 req0 dropped in the cycle after grant -> ack0 still pulses once with the correct result, and no second operation starts.
